// File: rtl/lwb_pkg.sv
// Shared defaults, pixel type and constant helpers for the line window buffer.
package lwb_pkg;

  localparam int LWB_DATA_W    = 8;
  localparam int LWB_LINE_LEN  = 1600;
  localparam int LWB_NUM_LINES = 3;
  localparam int LWB_Y_W       = 11;

  typedef logic [LWB_DATA_W-1:0] pixel_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // (sel - k) mod n, always non-negative; used to locate older lines in the RAM ring.
  function automatic int ring_sub(input int sel, input int k, input int n);
    return (((sel - k) % n) + n) % n;
  endfunction

endpackage

// File: rtl/lwb_line_ram.sv
// Single-port read-first line RAM with registered output; contents are never cleared.
module lwb_line_ram
  import lwb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1600,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// Streaming column generator for NUM_LINES-tall sliding-window kernels.
// Optional top-border replication: define LINE_WINDOW_EDGE_REPLICATE_EN.
module line_window_buffer
  import lwb_pkg::*;
#(
  parameter int DATA_W    = LWB_DATA_W,
  parameter int LINE_LEN  = LWB_LINE_LEN,
  parameter int NUM_LINES = LWB_NUM_LINES,
  parameter int Y_W       = LWB_Y_W,
  localparam int X_W      = clog2(LINE_LEN),
  localparam int S_W      = (NUM_LINES > 2) ? clog2(NUM_LINES - 1) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sof,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  output logic [NUM_LINES*DATA_W-1:0]   out_col,
  output logic [X_W-1:0]                out_x,
  output logic [Y_W-1:0]                out_y,
  output logic                          out_eol
);

  // Handshake: in_valid qualifies one pixel per cycle with no ready (the source is
  // never stalled); out_valid marks a column exactly one cycle after its pixel.

  localparam int             N_RAM  = NUM_LINES - 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(LINE_LEN - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(N_RAM - 1);

  logic [X_W-1:0]              x_cnt, x_eff;
  logic [Y_W-1:0]              y_cnt, y_eff;
  logic [S_W-1:0]              wr_sel, wr_sel_eff, wr_sel_d, rd_sel;
  logic                        emit;
  logic                        ram_en;
  logic [DATA_W-1:0]           din_d;
  logic [DATA_W-1:0]           ram_dout [N_RAM];
  logic [NUM_LINES*DATA_W-1:0] col_live, col_hold;

  // sof clears the position before the same-cycle pixel is placed.
  always_comb begin
    x_eff      = sof ? '0 : x_cnt;
    y_eff      = sof ? '0 : y_cnt;
    wr_sel_eff = sof ? '0 : wr_sel;
  end

  assign ram_en = in_valid & ~rst;

`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
  assign emit = in_valid;
`else
  logic primed, primed_eff;

  assign primed_eff = (sof ? 1'b0 : primed) | (y_eff == Y_W'(NUM_LINES - 1));
  assign emit       = in_valid & primed_eff;

  always_ff @(posedge clk) begin
    if (rst)           primed <= 1'b0;
    else if (in_valid) primed <= primed_eff;
    else if (sof)      primed <= 1'b0;
  end
`endif

  for (genvar i = 0; i < N_RAM; i++) begin : g_ram
    lwb_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (LINE_LEN),
      .ADDR_W (X_W)
    ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_en & (wr_sel_eff == S_W'(i))),
      .addr (x_eff),
      .din  (in_data),
      .dout (ram_dout[i])
    );
  end

  // Slot k reads the RAM k lines behind the one written for the emitted pixel.
  always_comb begin
    col_live           = '0;
    rd_sel             = '0;
    col_live[DATA_W-1:0] = din_d;
    for (int k = 1; k < NUM_LINES; k++) begin
      rd_sel = S_W'(ring_sub(int'(wr_sel_d), k, N_RAM));
      col_live[k*DATA_W +: DATA_W] = ram_dout[rd_sel];
`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
      if (int'(out_y) < k)
        col_live[k*DATA_W +: DATA_W] = (out_y == '0) ? din_d : ram_dout[0];
`endif
    end
  end

  assign out_col = out_valid ? col_live : col_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt     <= '0;
      y_cnt     <= '0;
      wr_sel    <= '0;
      wr_sel_d  <= '0;
      din_d     <= '0;
      col_hold  <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_eol   <= 1'b0;
    end else begin
      out_valid <= emit;
      if (out_valid) col_hold <= col_live;
      if (in_valid) begin
        din_d    <= in_data;
        wr_sel_d <= wr_sel_eff;
        if (x_eff == X_LAST) begin
          x_cnt  <= '0;
          y_cnt  <= y_eff + 1'b1;
          wr_sel <= (wr_sel_eff == S_LAST) ? '0 : wr_sel_eff + 1'b1;
        end else begin
          x_cnt  <= x_eff + 1'b1;
          y_cnt  <= y_eff;
          wr_sel <= wr_sel_eff;
        end
      end else if (sof) begin
        x_cnt  <= '0;
        y_cnt  <= '0;
        wr_sel <= '0;
      end
      if (emit) begin
        out_x   <= x_eff;
        out_y   <= y_eff;
        out_eol <= (x_eff == X_LAST);
      end
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: frame-level pixel model plus directed literal checks.
module tb_line_window_buffer;

  localparam int DW = 8;
  localparam int LL = 4;
  localparam int NL = 3;
  localparam int YW = 11;
  localparam int XW = 2;
  localparam int CW = NL * DW;
  localparam int EW = 2 + CW + XW + YW;
`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, sof, in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid, out_eol;
  logic [CW-1:0] out_col;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // model: pixels by (row since last sof/rst, column); hold values of the outputs
  int            pix [64][LL];
  int            m_x, m_y;
  bit            m_primed;
  logic [CW-1:0] h_col;
  logic [XW-1:0] h_x;
  logic [YW-1:0] h_y;
  logic          h_eol;

  always #5 clk = ~clk;

  line_window_buffer #(
    .DATA_W    (DW),
    .LINE_LEN  (LL),
    .NUM_LINES (NL),
    .Y_W       (YW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sof       (sof),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_col   (out_col),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_eol   (out_eol)
  );

  task automatic model(input bit r, input bit s, input bit v, input logic [DW-1:0] d);
    bit ev;
    int row;
    ev = 1'b0;
    if (r) begin
      m_x = 0; m_y = 0; m_primed = 1'b0;
      h_col = '0; h_x = '0; h_y = '0; h_eol = 1'b0;
    end else begin
      if (s) begin
        m_x = 0; m_y = 0; m_primed = 1'b0;
      end
      if (v) begin
        if (m_y >= NL - 1) m_primed = 1'b1;
        pix[m_y % 64][m_x] = int'(d);
        ev = m_primed || REPL;
        if (ev) begin
          for (int k = 0; k < NL; k++) begin
            row = (m_y >= k) ? m_y - k : 0;
            h_col[k*DW +: DW] = DW'(pix[row % 64][m_x]);
          end
          h_x   = XW'(m_x);
          h_y   = YW'(m_y);
          h_eol = (m_x == LL - 1);
        end
        m_x++;
        if (m_x == LL) begin
          m_x = 0;
          m_y = (m_y + 1) % (1 << YW);
        end
      end
    end
    exp_q.push_back({ev, h_eol, h_col, h_x, h_y});
  endtask

  task automatic step(input bit r, input bit s, input bit v, input logic [DW-1:0] d);
    @(negedge clk);
    rst = r; sof = s; in_valid = v; in_data = d;
    model(r, s, v, d);
  endtask

  task automatic lit(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin : compare
    logic [EW-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out_valid, out_eol, out_col, out_x, out_y} !== e) begin
        errors++;
        $display("FAIL cycle t=%0t got v=%0b eol=%0b col=%h x=%0d y=%0d exp v=%0b eol=%0b col=%h x=%0d y=%0d",
                 $time, out_valid, out_eol, out_col, out_x, out_y,
                 e[EW-1], e[EW-2], e[XW+YW +: CW], e[YW +: XW], e[YW-1:0]);
      end
    end
  end

  initial begin
    bit r, s, v;
    rst = 1'b1; sof = 1'b0; in_valid = 1'b0; in_data = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    @(posedge clk); #2;
    lit("reset_valid", out_valid, 0);
    lit("reset_col", out_col, 0);

    // back-to-back raster stream 0..15
    for (int p = 0; p < 16; p++) begin
      step(0, p == 0, 1, DW'(p));
      @(posedge clk); #2;
`ifdef LINE_WINDOW_EDGE_REPLICATE_EN
      if (p == 0) begin
        lit("r_p0_valid", out_valid, 1);
        lit("r_p0_col", out_col, 24'h000000);
      end
      if (p == 5) lit("r_p5_col", out_col, 24'h010105);
      if (p == 9) lit("r_p9_col", out_col, 24'h010509);
`else
      if (p == 7) lit("p7_valid", out_valid, 0);
      if (p == 8) begin
        lit("p8_valid", out_valid, 1);
        lit("p8_col", out_col, 24'h000408);
        lit("p8_x", out_x, 0);
        lit("p8_y", out_y, 2);
      end
      if (p == 11) begin
        lit("p11_col", out_col, 24'h03070B);
        lit("p11_eol", out_eol, 1);
      end
      if (p == 13) begin
        lit("p13_col", out_col, 24'h05090D);
        lit("p13_y", out_y, 3);
      end
`endif
    end

    // same stream with in_valid on every other cycle
    for (int i = 0; i < 32; i++) begin
      step(0, i == 0, i % 2 == 0, DW'(i / 2));
      @(posedge clk); #2;
      if (i == 16) lit("gap_p8_col", out_col, 24'h000408);
      if (i == 17) begin
        lit("gap_idle_valid", out_valid, 0);
        lit("gap_hold_col", out_col, 24'h000408);
      end
    end

    // sof restart at pixel 10 carrying 0xAA
    for (int p = 0; p < 24; p++) begin
      step(0, p == 0 || p == 10, 1, (p == 10) ? 8'hAA : DW'(p));
      @(posedge clk); #2;
`ifndef LINE_WINDOW_EDGE_REPLICATE_EN
      if (p == 10) lit("sof_p10_valid", out_valid, 0);
      if (p == 17) lit("sof_p17_valid", out_valid, 0);
`endif
      if (p == 18) begin
        lit("sof_p18_valid", out_valid, 1);
        lit("sof_p18_col", out_col, 24'hAA0E12);
        lit("sof_p18_y", out_y, 2);
      end
    end

    // reset in place of pixel 9
    for (int p = 0; p < 9; p++) step(0, p == 0, 1, DW'(p));
    step(1, 0, 1, 8'd9);
    @(posedge clk); #2;
    lit("rst_valid", out_valid, 0);
    lit("rst_x", out_x, 0);
    lit("rst_y", out_y, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 1, DW'(100 + i));
      @(posedge clk); #2;
`ifndef LINE_WINDOW_EDGE_REPLICATE_EN
      if (i == 7) lit("rst_p8_valid", out_valid, 0);
`endif
      if (i == 8) begin
        lit("rst_p9_valid", out_valid, 1);
        lit("rst_p9_col", out_col, 24'h64686C);
      end
    end

    // randomized traffic with gaps, occasional sof and reset
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 499) == 0);
      s = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 9) < 7);
      step(r, s, v, DW'($urandom_range(0, 255)));
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk); #3;
    lit("queue_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
